// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the OTTER PC sequencing control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        SRC_PC_4   = 3'd0,
        SRC_JALR   = 3'd1,
        SRC_BRANCH = 3'd2,
        SRC_JAL    = 3'd3,
        SRC_MTVEC  = 3'd4,
        SRC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [11:0] MRET_HI12 = 12'h302;

    function automatic logic is_mret(input logic [6:0]  opcode,
                                     input logic [2:0]  func3,
                                     input logic [11:0] hi12);
        return (opcode == OPC_SYSTEM) && (func3 == 3'b000) && (hi12 == MRET_HI12);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_seq_ctrl_br_cond_gen.sv
// ============================================================================
// Module      : br_cond_gen
// Description : Branch-taken decision from func3 and the comparator flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_cond_gen (
    input  logic [2:0] ir_func3,
    input  logic       br_eq,
    input  logic       br_lt,
    input  logic       br_ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (ir_func3)
            3'b000:  taken = br_eq;
            3'b001:  taken = ~br_eq;
            3'b100:  taken = br_lt;
            3'b101:  taken = ~br_lt;
            3'b110:  taken = br_ltu;
            3'b111:  taken = ~br_ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Multicycle FSM sequencing the OTTER PC, memory and regfile strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  ir_opcode,
    input  logic [2:0]  ir_func3,
    input  logic [11:0] ir_hi12,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        intr,
    input  logic        mie,
    input  logic        mem_ack,
    output logic        pc_write,
    output logic [2:0]  pc_source,
    output logic        mem_rden1,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic        rf_we,
    output logic        int_taken,
    output logic        mret_exec
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_intr_sync;
    logic                   w_taken;
    logic                   w_is_mret;
    logic                   w_int_req;
    logic                   w_retire;
    pc_src_t                w_pc_src;

    br_cond_gen u_br_cond_gen (
        .ir_func3 (ir_func3),
        .br_eq    (br_eq),
        .br_lt    (br_lt),
        .br_ltu   (br_ltu),
        .taken    (w_taken)
    );

    assign w_intr_sync = r_sync[SYNC_STAGES-1];
    assign w_is_mret   = is_mret(ir_opcode, ir_func3, ir_hi12);
    // MIE is still the pre-MRET value here, so an MRET must not itself trap.
    assign w_int_req   = w_intr_sync & mie & ~w_is_mret;
    assign pc_source   = w_pc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_sync  <= '0;
        end else begin
            r_state <= w_state_next;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], intr};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        pc_write     = 1'b0;
        w_pc_src     = SRC_PC_4;
        mem_rden1    = 1'b0;
        mem_rden2    = 1'b0;
        mem_we2      = 1'b0;
        rf_we        = 1'b0;
        int_taken    = 1'b0;
        mret_exec    = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_state_next = ST_FETCH;
            end

            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (mem_ack) begin
                    w_state_next = ST_EXEC;
                end
            end

            ST_EXEC: begin
                w_retire = 1'b1;
                pc_write = 1'b1;
                case (ir_opcode)
                    OPC_LOAD: begin
                        w_retire     = 1'b0;
                        pc_write     = 1'b0;
                        mem_rden2    = 1'b1;
                        w_state_next = ST_WB;
                    end
                    OPC_STORE: begin
                        mem_we2 = 1'b1;
                    end
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                        rf_we = 1'b1;
                    end
                    OPC_JAL: begin
                        rf_we    = 1'b1;
                        w_pc_src = SRC_JAL;
                    end
                    OPC_JALR: begin
                        rf_we    = 1'b1;
                        w_pc_src = SRC_JALR;
                    end
                    OPC_BRANCH: begin
                        w_pc_src = w_taken ? SRC_BRANCH : SRC_PC_4;
                    end
                    OPC_SYSTEM: begin
                        if (w_is_mret) begin
                            w_pc_src  = SRC_MEPC;
                            mret_exec = 1'b1;
                        end else begin
                            rf_we = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcodes advance the PC with no side effects.
                    end
                endcase
            end

            ST_WB: begin
                mem_rden2 = 1'b1;
                if (mem_ack) begin
                    w_retire = 1'b1;
                    rf_we    = 1'b1;
                    pc_write = 1'b1;
                end
            end

            ST_INTR: begin
                pc_write     = 1'b1;
                w_pc_src     = SRC_MTVEC;
                int_taken    = 1'b1;
                w_state_next = ST_FETCH;
            end

            default: begin
                w_state_next = ST_INIT;
            end
        endcase

        if (w_retire) begin
            w_state_next = w_int_req ? ST_INTR : ST_FETCH;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
// ============================================================================
// Module      : tb_pc_seq_ctrl
// Description : Scoreboard bench for pc_seq_ctrl: per-cycle expected strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  ir_opcode;
    logic [2:0]  ir_func3;
    logic [11:0] ir_hi12;
    logic        br_eq, br_lt, br_ltu;
    logic        intr, mie, mem_ack;
    logic        pc_write;
    logic [2:0]  pc_source;
    logic        mem_rden1, mem_rden2, mem_we2, rf_we, int_taken, mret_exec;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    pc_seq_ctrl #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_opcode (ir_opcode),
        .ir_func3  (ir_func3),
        .ir_hi12   (ir_hi12),
        .br_eq     (br_eq),
        .br_lt     (br_lt),
        .br_ltu    (br_ltu),
        .intr      (intr),
        .mie       (mie),
        .mem_ack   (mem_ack),
        .pc_write  (pc_write),
        .pc_source (pc_source),
        .mem_rden1 (mem_rden1),
        .mem_rden2 (mem_rden2),
        .mem_we2   (mem_we2),
        .rf_we     (rf_we),
        .int_taken (int_taken),
        .mret_exec (mret_exec)
    );

    // Starts high so the first sample (negedge) precedes the first active edge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // {pc_write, pc_source, rden1, rden2, we2, rf_we, int_taken, mret_exec}
    function automatic logic [9:0] ev(input logic pw, input logic [2:0] src,
                                      input logic r1, input logic r2, input logic we,
                                      input logic rf, input logic it, input logic mr);
        return {pw, src, r1, r2, we, rf, it, mr};
    endfunction

    localparam logic [9:0] E_IDLE  = 10'b0;
    localparam logic [9:0] E_FETCH = 10'b00_0010_0000;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check_eq(e.tag, {22'd0, pc_write, pc_source, mem_rden1, mem_rden2,
                             mem_we2, rf_we, int_taken, mret_exec}, {22'd0, e.v});
        end
    end

    task automatic cyc(input string tag, input logic [9:0] e);
        exp_t x;
        x.tag = tag;
        x.v   = e;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] hi);
        ir_opcode = op;
        ir_func3  = f3;
        ir_hi12   = hi;
    endtask

    // One-cycle fetch with immediate ack followed by the execute cycle.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [11:0] hi, input logic [9:0] e_exec);
        set_ir(op, f3, hi);
        mem_ack = 1'b1;
        cyc({tag, "_fetch"}, E_FETCH);
        cyc({tag, "_exec"}, e_exec);
    endtask

    initial begin
        rst_n = 1'b0;
        set_ir(7'b0010011, 3'b000, 12'h000);
        {br_eq, br_lt, br_ltu} = 3'b000;
        intr    = 1'b0;
        mie     = 1'b0;
        mem_ack = 1'b0;

        cyc("reset0", E_IDLE);
        cyc("reset1", E_IDLE);
        rst_n = 1'b1;
        cyc("init", E_IDLE);
        cyc("fetch_wait0", E_FETCH);
        cyc("fetch_wait1", E_FETCH);

        // Reset asserted while fetching: strobes drop without waiting for a clock.
        rst_n = 1'b0;
        cyc("rst_mid_fetch", E_IDLE);
        rst_n = 1'b1;
        cyc("init_again", E_IDLE);
        cyc("fetch_after_rst", E_FETCH);

        run_instr("addi_a", 7'b0010011, 3'b000, 12'h005, ev(1, 0, 0, 0, 0, 1, 0, 0));
        run_instr("addi_b", 7'b0010011, 3'b000, 12'h001, ev(1, 0, 0, 0, 0, 1, 0, 0));
        run_instr("lui",    7'b0110111, 3'b000, 12'h123, ev(1, 0, 0, 0, 0, 1, 0, 0));

        br_eq = 1'b1;
        run_instr("beq_t",  7'b1100011, 3'b000, 12'h000, ev(1, 2, 0, 0, 0, 0, 0, 0));
        br_eq = 1'b0;
        run_instr("beq_nt", 7'b1100011, 3'b000, 12'h000, ev(1, 0, 0, 0, 0, 0, 0, 0));
        run_instr("bne_t",  7'b1100011, 3'b001, 12'h000, ev(1, 2, 0, 0, 0, 0, 0, 0));
        br_ltu = 1'b0;
        run_instr("bgeu_t", 7'b1100011, 3'b111, 12'h000, ev(1, 2, 0, 0, 0, 0, 0, 0));
        br_ltu = 1'b1;
        run_instr("bgeu_nt", 7'b1100011, 3'b111, 12'h000, ev(1, 0, 0, 0, 0, 0, 0, 0));
        run_instr("bltu_t", 7'b1100011, 3'b110, 12'h000, ev(1, 2, 0, 0, 0, 0, 0, 0));
        br_lt = 1'b1;
        run_instr("blt_t",  7'b1100011, 3'b100, 12'h000, ev(1, 2, 0, 0, 0, 0, 0, 0));
        run_instr("bge_nt", 7'b1100011, 3'b101, 12'h000, ev(1, 0, 0, 0, 0, 0, 0, 0));
        {br_eq, br_lt, br_ltu} = 3'b111;
        run_instr("f3_010", 7'b1100011, 3'b010, 12'h000, ev(1, 0, 0, 0, 0, 0, 0, 0));
        run_instr("f3_011", 7'b1100011, 3'b011, 12'h000, ev(1, 0, 0, 0, 0, 0, 0, 0));
        {br_eq, br_lt, br_ltu} = 3'b000;

        // Load with the data ack arriving after three wait cycles.
        set_ir(7'b0000011, 3'b010, 12'h000);
        mem_ack = 1'b1;
        cyc("lw_fetch", E_FETCH);
        mem_ack = 1'b0;
        cyc("lw_exec", ev(0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) cyc("lw_wb_wait", ev(0, 0, 0, 1, 0, 0, 0, 0));
        mem_ack = 1'b1;
        cyc("lw_wb_ack", ev(1, 0, 0, 1, 0, 1, 0, 0));

        run_instr("sw",   7'b0100011, 3'b010, 12'h000, ev(1, 0, 0, 0, 1, 0, 0, 0));
        run_instr("jalr", 7'b1100111, 3'b000, 12'h000, ev(1, 1, 0, 0, 0, 1, 0, 0));
        run_instr("csrrw", 7'b1110011, 3'b001, 12'h305, ev(1, 0, 0, 0, 0, 1, 0, 0));
        run_instr("unk",  7'b1111111, 3'b000, 12'h000, ev(1, 0, 0, 0, 0, 0, 0, 0));

        // Interrupt enabled: JAL retires, then the trap entry cycle.
        set_ir(7'b1101111, 3'b000, 12'h000);
        intr    = 1'b1;
        mie     = 1'b1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) cyc("jal_irq_fwait", E_FETCH);
        mem_ack = 1'b1;
        cyc("jal_irq_fetch", E_FETCH);
        cyc("jal_irq_exec", ev(1, 3, 0, 0, 0, 1, 0, 0));
        cyc("irq_entry", ev(1, 4, 0, 0, 0, 0, 1, 0));
        mem_ack = 1'b0;
        cyc("irq_refetch", E_FETCH);

        // Interrupt line high but masked: no trap entry.
        mie = 1'b0;
        run_instr("jal_masked", 7'b1101111, 3'b000, 12'h000, ev(1, 3, 0, 0, 0, 1, 0, 0));
        mem_ack = 1'b0;
        cyc("jal_masked_next", E_FETCH);

        // MRET with a pending, enabled interrupt must not trap in its own cycle.
        mie = 1'b1;
        run_instr("mret", 7'b1110011, 3'b000, 12'h302, ev(1, 5, 0, 0, 0, 0, 0, 1));
        mem_ack = 1'b0;
        cyc("mret_next", E_FETCH);

        // Lowering INTR drains the synchronizer; a later ADDI then retires normally.
        intr = 1'b0;
        for (int i = 0; i < 3; i++) cyc("drain_fetch", E_FETCH);
        run_instr("addi_post", 7'b0010011, 3'b000, 12'h000, ev(1, 0, 0, 0, 0, 1, 0, 0));
        mem_ack = 1'b0;
        cyc("addi_post_next", E_FETCH);

        check_eq("scoreboard_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
